fp_job_queue: RTL and testbench

- Parametrised Avalon-MM slave that queues floating-point jobs and streams them into an external fixed-function FP core (custom-instruction style: dataa/datab/n/start/done).
- Generalises the single-shot operand-register accelerator:
  - command FIFO of operand pairs with per-job opcode;
  - pipelined, credit-limited issue;
  - result FIFO;
  - sticky status and completion counter.
- Sits between the Nios II data master and the FP core in the DMA test system.

---
 rtl/fp_job_queue.sv | 184 ++++++++++++++++++
 tb/tb_fp_job_queue.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_job_queue.sv
// fp_job_queue -- Avalon-MM slave that queues floating-point jobs for an
// external fixed-function FP core (dataa/datab/n/start/done handshake).
//
// Jobs are built by writing OPA then OPB; the OPB write pushes
// {A, B, opcode} into a command FIFO. Jobs issue to the core one per cycle
// while result-FIFO credit remains, and results come back in order into a
// result FIFO read through the RESULT register.
//
// Ports:
//   clk, reset                 single clock, synchronous active-low reset
//   slaveaddress/write/...     Avalon-MM slave (registered read data,
//                              readdatavalid one cycle after each read,
//                              waitrequest only on an OPB write to a full
//                              command FIFO)
//   core_dataa/datab/n/start   job issue towards the FP core
//   core_done/core_result      in-order completion from the FP core
//
// Register map (word addresses):
//   0 OPA  1 OPB(push)  2 CTRL(opcode, bit8 flush results, bit9 clear
//   stickies)  3 STATUS  4 RESULT(pop)  5 DONECNT  6-7 read as 0
module fp_job_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int OPC_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        slaveaddress,
    input  logic              slavewrite,
    input  logic [DATA_W-1:0] slavewritedata,
    input  logic              slaveread,
    output logic [DATA_W-1:0] slavereaddata,
    output logic              slavereaddatavalid,
    output logic              slavewaitrequest,
    output logic [DATA_W-1:0] core_dataa,
    output logic [DATA_W-1:0] core_datab,
    output logic [OPC_W-1:0]  core_n,
    output logic              core_start,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CW1 = CW + 1;
    localparam int EW  = 2 * DATA_W + OPC_W;
    localparam logic [OPC_W-1:0] OPC_RESET = OPC_W'(253);

    // Storage: small FIFOs read asynchronously so the head is available
    // in the issue cycle without an extra pipeline stage.
    logic [EW-1:0]     cmd_mem [DEPTH];
    logic [DATA_W-1:0] res_mem [DEPTH];

    logic [AW-1:0]     cmd_wr_reg, cmd_rd_reg, res_wr_reg, res_rd_reg;
    logic [CW-1:0]     cmd_count_reg, res_count_reg, in_flight_reg;
    logic [DATA_W-1:0] opa_reg, opb_reg, done_cnt_reg;
    logic [DATA_W-1:0] dataa_reg, datab_reg;
    logic [OPC_W-1:0]  opcode_reg, n_reg;
    logic              underflow_reg, spurious_reg;

    logic              cmd_full, wr_opa, push, wr_ctrl, flush, clear_sticky;
    logic              issue, rd_result, pop, underflow_evt, complete, spurious_evt;
    logic [CW1-1:0]    credit_sum;
    logic [EW-1:0]     head;
    logic              busy;
    logic [31:0]       status_word;
    logic [DATA_W-1:0] read_value;

    assign cmd_full      = (cmd_count_reg == CW'(DEPTH));
    assign wr_opa        = slavewrite && (slaveaddress == 3'd0);
    assign push          = slavewrite && (slaveaddress == 3'd1) && !cmd_full;
    assign wr_ctrl       = slavewrite && (slaveaddress == 3'd2);
    assign flush         = wr_ctrl && slavewritedata[8];
    assign clear_sticky  = wr_ctrl && slavewritedata[9];
    assign slavewaitrequest = slavewrite && (slaveaddress == 3'd1) && cmd_full;

    // Credit check: every job in flight already owns a result-FIFO slot,
    // so a completion can never find the result FIFO full.
    assign credit_sum    = {1'b0, in_flight_reg} + {1'b0, res_count_reg};
    assign issue         = (cmd_count_reg != '0) && (credit_sum < CW1'(DEPTH));

    assign rd_result     = slaveread && (slaveaddress == 3'd4);
    assign pop           = rd_result && (res_count_reg != '0);
    assign underflow_evt = rd_result && (res_count_reg == '0);
    assign complete      = core_done && (in_flight_reg != '0);
    assign spurious_evt  = core_done && (in_flight_reg == '0);

    assign head = cmd_mem[cmd_rd_reg];

    // Core operands follow the FIFO head in the issue cycle and hold the
    // last issued job otherwise.
    assign core_start = issue;
    assign core_dataa = issue ? head[EW-1 -: DATA_W]   : dataa_reg;
    assign core_datab = issue ? head[OPC_W +: DATA_W]  : datab_reg;
    assign core_n     = issue ? head[OPC_W-1:0]        : n_reg;

    assign busy = (cmd_count_reg != '0) || (in_flight_reg != '0) || (res_count_reg != '0);
    assign status_word = {5'd0, busy, spurious_reg, underflow_reg,
                          8'(in_flight_reg), 8'(res_count_reg), 8'(cmd_count_reg)};

    always_comb begin
        read_value = '0;
        case (slaveaddress)
            3'd0: read_value = opa_reg;
            3'd1: read_value = opb_reg;
            3'd2: read_value = DATA_W'(opcode_reg);
            3'd3: read_value = DATA_W'(status_word);
            3'd4: if (res_count_reg != '0) read_value = res_mem[res_rd_reg];
            3'd5: read_value = done_cnt_reg;
            default: read_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            cmd_mem[cmd_wr_reg] <= {opa_reg, slavewritedata, opcode_reg};
        if (complete)
            res_mem[res_wr_reg] <= core_result;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd_wr_reg         <= '0;
            cmd_rd_reg         <= '0;
            res_wr_reg         <= '0;
            res_rd_reg         <= '0;
            cmd_count_reg      <= '0;
            res_count_reg      <= '0;
            in_flight_reg      <= '0;
            opa_reg            <= '0;
            opb_reg            <= '0;
            done_cnt_reg       <= '0;
            dataa_reg          <= '0;
            datab_reg          <= '0;
            opcode_reg         <= OPC_RESET;
            n_reg              <= OPC_RESET;
            underflow_reg      <= 1'b0;
            spurious_reg       <= 1'b0;
            slavereaddata      <= '0;
            slavereaddatavalid <= 1'b0;
        end else begin
            if (wr_opa)
                opa_reg <= slavewritedata;
            if (push) begin
                opb_reg    <= slavewritedata;
                cmd_wr_reg <= cmd_wr_reg + AW'(1);
            end
            if (wr_ctrl)
                opcode_reg <= slavewritedata[OPC_W-1:0];
            if (issue) begin
                cmd_rd_reg <= cmd_rd_reg + AW'(1);
                dataa_reg  <= head[EW-1 -: DATA_W];
                datab_reg  <= head[OPC_W +: DATA_W];
                n_reg      <= head[OPC_W-1:0];
            end
            cmd_count_reg <= cmd_count_reg + CW'(push) - CW'(issue);
            in_flight_reg <= in_flight_reg + CW'(issue) - CW'(complete);

            // Flush empties the result FIFO first; a completion in the same
            // cycle then lands as the only entry.
            res_wr_reg <= res_wr_reg + AW'(complete);
            if (flush) begin
                res_rd_reg    <= res_wr_reg;
                res_count_reg <= CW'(complete);
            end else begin
                res_rd_reg    <= res_rd_reg + AW'(pop);
                res_count_reg <= res_count_reg + CW'(complete) - CW'(pop);
            end
            done_cnt_reg <= done_cnt_reg + DATA_W'(complete);

            // New events win over a clear issued in the same cycle.
            if (underflow_evt)
                underflow_reg <= 1'b1;
            else if (clear_sticky)
                underflow_reg <= 1'b0;
            if (spurious_evt)
                spurious_reg <= 1'b1;
            else if (clear_sticky)
                spurious_reg <= 1'b0;

            slavereaddata      <= slaveread ? read_value : '0;
            slavereaddatavalid <= slaveread;
        end
    end
endmodule

// File: tb/tb_fp_job_queue.sv
// Self-checking bench for fp_job_queue: directed scenarios plus randomized
// job bursts, checked against a queue-based reference model and a
// behavioural FP-core model that returns a preassigned answer per job.
module tb_fp_job_queue;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int OPC_W  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [2:0]        slaveaddress = '0;
    logic              slavewrite = 1'b0;
    logic [DATA_W-1:0] slavewritedata = '0;
    logic              slaveread = 1'b0;
    logic [DATA_W-1:0] slavereaddata;
    logic              slavereaddatavalid;
    logic              slavewaitrequest;
    logic [DATA_W-1:0] core_dataa, core_datab;
    logic [OPC_W-1:0]  core_n;
    logic              core_start;
    logic              core_done = 1'b0;
    logic [DATA_W-1:0] core_result = '0;

    fp_job_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OPC_W(OPC_W)) dut (
        .clk(clk), .reset(reset),
        .slaveaddress(slaveaddress), .slavewrite(slavewrite),
        .slavewritedata(slavewritedata), .slaveread(slaveread),
        .slavereaddata(slavereaddata), .slavereaddatavalid(slavereaddatavalid),
        .slavewaitrequest(slavewaitrequest),
        .core_dataa(core_dataa), .core_datab(core_datab), .core_n(core_n),
        .core_start(core_start), .core_done(core_done), .core_result(core_result)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; logic [31:0] b; logic [7:0] n; logic [31:0] ans; } job_t;
    typedef struct { int ready; logic [31:0] ans; } pend_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    job_t        exp_jobs[$];   // submitted, not yet seen at core_start
    pend_t       pending[$];    // started in the core model, not yet done
    logic [31:0] exp_res[$];    // results the queue should hold, in order
    logic [31:0] m_done_cnt = 0;
    logic [7:0]  m_opcode = 8'd253;
    bit          m_under = 0, m_spur = 0;
    bit          core_stall = 0, inject = 0;
    int          core_lat = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // FP core model: checks each issued job, returns its answer after a
    // latency, in order, one per cycle; can be stalled or forced to emit a
    // done with nothing outstanding.
    initial begin
        job_t j;
        int   lat;
        forever begin
            @(negedge clk);
            cyc++;
            core_done = 1'b0;
            if (!reset) begin
                pending.delete();
                exp_jobs.delete();
            end else begin
                if (core_start === 1'b1) begin
                    check("issue_expected", 32'(exp_jobs.size() > 0), 32'd1);
                    if (exp_jobs.size() > 0) begin
                        j = exp_jobs.pop_front();
                        check("core_dataa", core_dataa, j.a);
                        check("core_datab", core_datab, j.b);
                        check("core_n", {24'd0, core_n}, {24'd0, j.n});
                        lat = (core_lat != 0) ? core_lat : int'($urandom_range(1, 6));
                        pending.push_back('{cyc + lat, j.ans});
                    end
                end
                if (inject) begin
                    core_done   = 1'b1;
                    core_result = 32'hDEADBEEF;
                    inject      = 0;
                end else if (!core_stall && pending.size() > 0 && pending[0].ready <= cyc) begin
                    core_done   = 1'b1;
                    core_result = pending[0].ans;
                    exp_res.push_back(pending[0].ans);
                    m_done_cnt++;
                    void'(pending.pop_front());
                end
            end
        end
    end

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        slaveaddress = a; slavewritedata = d; slavewrite = 1'b1;
        #1;
        while (slavewaitrequest === 1'b1 && n < 300) begin
            @(negedge clk); #1; n++;
        end
        check("write_not_stalled", {31'd0, slavewaitrequest}, 32'd0);
        @(negedge clk);
        slavewrite = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        slaveaddress = a; slaveread = 1'b1;
        @(negedge clk);
        slaveread = 1'b0;
        check("rd_valid", {31'd0, slavereaddatavalid}, 32'd1);
        d = slavereaddata;
        @(negedge clk);
        check("rd_valid_drop", {31'd0, slavereaddatavalid}, 32'd0);
        check("rd_data_idle", slavereaddata, 32'd0);
    endtask

    task automatic read_check(input logic [2:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        do_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic read_result(input string tag);
        logic [31:0] e;
        if (exp_res.size() > 0) e = exp_res.pop_front();
        else begin e = 32'd0; m_under = 1; end
        read_check(3'd4, e, tag);
    endtask

    task automatic check_status(input string tag, input int cmd, input int inf);
        int          res;
        logic        busy;
        logic [31:0] w;
        res  = exp_res.size();
        busy = (cmd != 0) || (inf != 0) || (res != 0);
        w    = {5'd0, busy, m_spur, m_under, 8'(inf), 8'(res), 8'(cmd)};
        read_check(3'd3, w, tag);
    endtask

    task automatic submit(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ans);
        job_t j;
        j.a = a; j.b = b; j.n = m_opcode; j.ans = ans;
        exp_jobs.push_back(j);
        do_write(3'd0, a);
        do_write(3'd1, b);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_jobs.size() > 0 || pending.size() > 0) && n < 2000) begin
            @(negedge clk); n++;
        end
        repeat (3) @(negedge clk);
        check("idle_reached", 32'(exp_jobs.size() + pending.size()), 32'd0);
    endtask

    task automatic wait_results(input int count);
        int n = 0;
        while (exp_res.size() < count && n < 2000) begin
            @(negedge clk); n++;
        end
        repeat (2) @(negedge clk);
        check("results_arrived", 32'(exp_res.size() >= count), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a17, b17, ans17, e0, e1;
        int          k, nrd;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_core_start", {31'd0, core_start}, 32'd0);
        check("rst_core_n", {24'd0, core_n}, 32'd253);
        check("rst_core_dataa", core_dataa, 32'd0);
        check("rst_rdvalid", {31'd0, slavereaddatavalid}, 32'd0);
        check("rst_rddata", slavereaddata, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_status("rst_status", 0, 0);
        read_check(3'd2, 32'd253, "rst_opcode");
        read_check(3'd5, 32'd0, "rst_donecnt");

        // ---- single directed job ----
        core_lat = 5;
        submit(32'h3F800000, 32'h40000000, 32'h40400000);
        check("t1_start", {31'd0, core_start}, 32'd1);
        check("t1_dataa", core_dataa, 32'h3F800000);
        check("t1_datab", core_datab, 32'h40000000);
        check("t1_n", {24'd0, core_n}, 32'd253);
        wait_idle();
        read_result("t1_result");
        read_check(3'd5, m_done_cnt, "t1_donecnt");
        core_lat = 0;

        // ---- credit limit and command-FIFO backpressure ----
        core_stall = 1;
        for (int i = 0; i < DEPTH; i++) submit($urandom, $urandom, $urandom);
        repeat (3) @(negedge clk);
        check_status("credit_full", 0, DEPTH);
        for (int i = 0; i < DEPTH; i++) submit($urandom, $urandom, $urandom);
        check_status("cmd_full", DEPTH, DEPTH);
        a17 = $urandom; b17 = $urandom; ans17 = $urandom;
        exp_jobs.push_back('{a17, b17, m_opcode, ans17});
        do_write(3'd0, a17);
        @(negedge clk);
        slaveaddress = 3'd1; slavewritedata = b17; slavewrite = 1'b1;
        #1;
        check("stall_held", {31'd0, slavewaitrequest}, 32'd1);
        repeat (4) begin
            @(negedge clk); #1;
            check("stall_held", {31'd0, slavewaitrequest}, 32'd1);
            check("stall_no_issue", {31'd0, core_start}, 32'd0);
        end
        core_stall = 0;
        wait_results(DEPTH);
        #1;
        check("stall_until_pop", {31'd0, slavewaitrequest}, 32'd1);
        @(negedge clk);
        slavewrite = 1'b0;
        read_result("stall_res_first");
        do_write(3'd1, b17);
        wait_results(2);
        e0 = exp_res.pop_front(); e1 = exp_res.pop_front();
        @(negedge clk);
        slaveaddress = 3'd4; slaveread = 1'b1;
        @(negedge clk);
        check("b2b_valid0", {31'd0, slavereaddatavalid}, 32'd1);
        check("b2b_data0", slavereaddata, e0);
        @(negedge clk);
        slaveread = 1'b0;
        check("b2b_valid1", {31'd0, slavereaddatavalid}, 32'd1);
        check("b2b_data1", slavereaddata, e1);
        for (int i = 0; i < 2 * DEPTH - 2; i++) begin
            wait_results(1);
            read_result("drain_res");
        end
        wait_idle();
        check_status("drained", 0, 0);

        // ---- underflow sticky ----
        read_result("underflow_data");
        check_status("underflow_set", 0, 0);
        do_write(3'd2, 32'h200 | {24'd0, m_opcode});
        m_under = 0; m_spur = 0;
        check_status("underflow_clr", 0, 0);

        // ---- spurious done ----
        inject = 1;
        repeat (4) @(negedge clk);
        m_spur = 1;
        check_status("spurious_set", 0, 0);
        read_check(3'd5, m_done_cnt, "spurious_donecnt");
        do_write(3'd2, 32'h200 | {24'd0, m_opcode});
        m_spur = 0;

        // ---- opcode change and flush ----
        do_write(3'd2, 32'h0FC);
        m_opcode = 8'hFC;
        for (int i = 0; i < 3; i++) submit($urandom, $urandom, $urandom);
        wait_idle();
        check("n_hold", {24'd0, core_n}, 32'h0FC);
        check_status("three_stored", 0, 0);
        do_write(3'd2, 32'h1FC);
        exp_res.delete();
        check_status("flushed", 0, 0);
        submit($urandom, $urandom, $urandom);
        wait_idle();
        read_result("after_flush");

        // ---- randomized bursts ----
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                m_opcode = 8'($urandom);
                do_write(3'd2, {24'd0, m_opcode});
            end
            if (exp_res.size() < DEPTH) begin
                k = $urandom_range(1, DEPTH - exp_res.size());
                for (int i = 0; i < k; i++) submit($urandom, $urandom, $urandom);
            end
            wait_idle();
            check_status("rand_status", 0, 0);
            if ($urandom_range(0, 3) == 0) begin
                do_write(3'd2, 32'h100 | {24'd0, m_opcode});
                exp_res.delete();
            end else begin
                nrd = $urandom_range(0, exp_res.size());
                for (int i = 0; i < nrd; i++) read_result("rand_res");
            end
        end
        read_check(3'd5, m_done_cnt, "rand_donecnt");

        // ---- mid-stream reset ----
        core_stall = 1;
        for (int i = 0; i < 3; i++) submit($urandom, $urandom, $urandom);
        repeat (3) @(negedge clk);
        check_status("pre_reset", 0, 3);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_res.delete();
        m_opcode = 8'd253; m_done_cnt = 0; m_under = 0; m_spur = 0;
        core_stall = 0;
        @(negedge clk);
        check_status("post_reset", 0, 0);
        read_check(3'd2, 32'd253, "post_reset_opcode");
        inject = 1;
        repeat (4) @(negedge clk);
        m_spur = 1;
        check_status("post_reset_spurious", 0, 0);
        read_check(3'd5, 32'd0, "post_reset_donecnt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
